// File: rtl/ex_stage_mdu.sv
// ex_stage_mdu
// Execute stage of the 5-stage MIPS pipeline. It holds operand forwarding,
// the immediate-select ALU and an iterative multiply/divide unit (MDU) that
// owns HI/LO. One radix-2 step is done per cycle. The front of the pipeline
// is stalled while a multiply or divide runs.
//
// Ports
//   clk                       rising-edge clock
//   reset                     synchronous, active-low reset
//   id_ex_instr[31:0]         EX instruction (only funct [5:0] is decoded)
//   id_ex_valid               EX instruction is real (not a bubble)
//   id_ex_alu_op[1:0]         ALUOp from the control unit
//   id_ex_reg1/reg2           register-file operands
//   id_ex_imm_value           sign-extended immediate
//   id_ex_alu_src             1 selects the immediate as ALU operand B
//   ex_mem_alu_result         forward source from EX/MEM
//   mem_wb_write_back_result  forward source from MEM/WB
//   Forward_A/Forward_B       forward selects (01 = MEM/WB, 10 = EX/MEM)
//   alu_in2_out               forwarded rt value, used as store data
//   alu_result                EX result
//   ex_stall                  hold the front end and bubble EX/MEM
//   hi_out/lo_out             current HI/LO
module ex_stage_mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     id_ex_instr,
    input  logic            id_ex_valid,
    input  logic [1:0]      id_ex_alu_op,
    input  logic [XLEN-1:0] id_ex_reg1,
    input  logic [XLEN-1:0] id_ex_reg2,
    input  logic [XLEN-1:0] id_ex_imm_value,
    input  logic            id_ex_alu_src,
    input  logic [XLEN-1:0] ex_mem_alu_result,
    input  logic [XLEN-1:0] mem_wb_write_back_result,
    input  logic [1:0]      Forward_A,
    input  logic [1:0]      Forward_B,
    output logic [XLEN-1:0] alu_in2_out,
    output logic [XLEN-1:0] alu_result,
    output logic            ex_stall,
    output logic [XLEN-1:0] hi_out,
    output logic [XLEN-1:0] lo_out
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST_STEP = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } mdu_state_t;

    mdu_state_t state_q, state_d;

    logic [5:0] funct;
    logic       unused_instr;

    assign funct        = id_ex_instr[5:0];
    assign unused_instr = ^id_ex_instr[31:6];

    // ------------------------------------------------------------------
    // Forwarding and operand selection
    // ------------------------------------------------------------------
    logic [XLEN-1:0] fwd_a, fwd_b, op_b;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned and infers a latch.
        fwd_a = id_ex_reg1;
        fwd_b = id_ex_reg2;
        case (Forward_A)
            2'b01:   fwd_a = mem_wb_write_back_result;
            2'b10:   fwd_a = ex_mem_alu_result;
            default: fwd_a = id_ex_reg1;
        endcase
        case (Forward_B)
            2'b01:   fwd_b = mem_wb_write_back_result;
            2'b10:   fwd_b = ex_mem_alu_result;
            default: fwd_b = id_ex_reg2;
        endcase
    end

    assign op_b        = id_ex_alu_src ? id_ex_imm_value : fwd_b;
    assign alu_in2_out = fwd_b;

    // ------------------------------------------------------------------
    // MDU instruction decode (bubbles never reach the MDU)
    // ------------------------------------------------------------------
    logic mdu_sel, start_op, is_mfhi, is_mflo, is_mthi, is_mtlo;

    assign mdu_sel  = id_ex_valid && (id_ex_alu_op == 2'b10);
    assign start_op = mdu_sel && (funct == F_MULT || funct == F_MULTU ||
                                  funct == F_DIV  || funct == F_DIVU);
    assign is_mfhi  = mdu_sel && (funct == F_MFHI);
    assign is_mflo  = mdu_sel && (funct == F_MFLO);
    assign is_mthi  = mdu_sel && (funct == F_MTHI);
    assign is_mtlo  = mdu_sel && (funct == F_MTLO);

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [XLEN-1:0] alu_val;
    logic [XLEN-1:0] hi_q, lo_q;

    always_comb begin
        alu_val = '0;
        case (id_ex_alu_op)
            2'b01: alu_val = fwd_a - op_b;
            2'b10: begin
                case (funct)
                    F_ADD, F_ADDU: alu_val = fwd_a + op_b;
                    F_SUB, F_SUBU: alu_val = fwd_a - op_b;
                    F_AND:         alu_val = fwd_a & op_b;
                    F_OR:          alu_val = fwd_a | op_b;
                    F_XOR:         alu_val = fwd_a ^ op_b;
                    F_NOR:         alu_val = ~(fwd_a | op_b);
                    F_SLT:         alu_val = {{(XLEN-1){1'b0}},
                                              ($signed(fwd_a) < $signed(op_b))};
                    F_SLTU:        alu_val = {{(XLEN-1){1'b0}}, (fwd_a < op_b)};
                    default:       alu_val = '0;
                endcase
            end
            default: alu_val = fwd_a + op_b;
        endcase
    end

    // MFHI/MFLO read the registers directly, so a read right after the DONE
    // cycle already sees the new result.
    always_comb begin
        alu_result = alu_val;
        if (is_mfhi) begin
            alu_result = hi_q;
        end else if (is_mflo) begin
            alu_result = lo_q;
        end
    end

    // ------------------------------------------------------------------
    // MDU datapath
    // ------------------------------------------------------------------
    logic [CW-1:0]   count_q;
    logic [XLEN-1:0] acc_hi_q;   // partial product high half / remainder
    logic [XLEN-1:0] acc_lo_q;   // multiplier shifting out / quotient shifting in
    logic [XLEN-1:0] mcand_q;    // multiplicand or divisor magnitude
    logic [XLEN-1:0] src_a_q;    // raw dividend, returned in HI on divide by zero
    logic            op_div_q, neg_q_q, neg_r_q, div_zero_q, div_ovf_q;

    logic            issue, finish;
    logic            op_signed, a_neg, b_neg;
    logic [XLEN-1:0] mag_a, mag_b;

    assign issue     = (state_q == S_IDLE) && start_op;
    assign finish    = (state_q == S_BUSY) && (count_q == LAST_STEP);
    // MULT and DIV have funct[0] = 0; MULTU and DIVU have funct[0] = 1.
    assign op_signed = ~funct[0];
    assign a_neg     = op_signed & fwd_a[XLEN-1];
    assign b_neg     = op_signed & fwd_b[XLEN-1];
    assign mag_a     = a_neg ? -fwd_a : fwd_a;
    assign mag_b     = b_neg ? -fwd_b : fwd_b;

    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic [XLEN-1:0] step_hi, step_lo;

    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
        div_shift = {acc_hi_q, acc_lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, mcand_q};
        step_hi   = mul_sum[XLEN:1];
        step_lo   = {mul_sum[0], acc_lo_q[XLEN-1:1]};
        if (op_div_q) begin
            // Restoring step: keep the trial subtraction only if it did not
            // borrow, and shift the matching quotient bit in.
            if (!div_diff[XLEN]) begin
                step_hi = div_diff[XLEN-1:0];
                step_lo = {acc_lo_q[XLEN-2:0], 1'b1};
            end else begin
                step_hi = div_shift[XLEN-1:0];
                step_lo = {acc_lo_q[XLEN-2:0], 1'b0};
            end
        end
    end

    // Sign correction and divide corner cases, applied on the last step.
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   fin_hi, fin_lo;

    always_comb begin
        prod   = {step_hi, step_lo};
        prod_s = neg_q_q ? -prod : prod;
        fin_hi = prod_s[2*XLEN-1:XLEN];
        fin_lo = prod_s[XLEN-1:0];
        if (op_div_q) begin
            if (div_zero_q) begin
                fin_hi = src_a_q;
                fin_lo = '1;
            end else if (div_ovf_q) begin
                fin_hi = '0;
                fin_lo = MOST_NEG;
            end else begin
                fin_hi = neg_r_q ? -step_hi : step_hi;
                fin_lo = neg_q_q ? -step_lo : step_lo;
            end
        end
    end

    // ------------------------------------------------------------------
    // MDU control
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_op) state_d = S_BUSY;
            S_BUSY:  if (count_q == LAST_STEP) state_d = S_DONE;
            // DONE lasts one cycle so the start op still sitting in EX
            // cannot retrigger the unit.
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign ex_stall = (state_q == S_BUSY) || issue;

    always_ff @(posedge clk) begin
        // NOTE: all state in clocked blocks uses non-blocking assignments so
        // every register samples the values from before the edge.
        if (!reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            if (issue) begin
                count_q <= '0;
            end else if (state_q == S_BUSY) begin
                count_q <= count_q + 1'b1;
            end
            if (finish) begin
                hi_q <= fin_hi;
                lo_q <= fin_lo;
            end else if (!ex_stall) begin
                if (is_mthi) hi_q <= fwd_a;
                if (is_mtlo) lo_q <= fwd_a;
            end
        end
    end

    // NOTE: the working registers are not reset; they are fully loaded on
    // every issue and only read while BUSY, so a reset adds nothing.
    always_ff @(posedge clk) begin
        if (issue) begin
            op_div_q   <= funct[1];
            neg_q_q    <= a_neg ^ b_neg;
            neg_r_q    <= a_neg;
            div_zero_q <= (fwd_b == '0);
            div_ovf_q  <= op_signed && (fwd_a == MOST_NEG) && (fwd_b == '1);
            src_a_q    <= fwd_a;
            acc_hi_q   <= '0;
            acc_lo_q   <= funct[1] ? mag_a : mag_b;
            mcand_q    <= funct[1] ? mag_b : mag_a;
        end else if (state_q == S_BUSY) begin
            acc_hi_q   <= step_hi;
            acc_lo_q   <= step_lo;
        end
    end

    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule
